// File: rtl/instr_mem_responder_if.sv
// Instruction-fetch bus between a fetch stage (master) and the instruction memory responder (slave).
interface instr_mem_responder_if;
    logic        instr_req_i;
    logic        instr_gnt_o;
    logic [31:0] instr_addr_i;
    logic [31:0] instr_rdata_o;
    logic        instr_rvalid_o;
    logic        instr_err_o;

    modport slave (
        input  instr_req_i,
        input  instr_addr_i,
        output instr_gnt_o,
        output instr_rdata_o,
        output instr_rvalid_o,
        output instr_err_o
    );

    modport master (
        output instr_req_i,
        output instr_addr_i,
        input  instr_gnt_o,
        input  instr_rdata_o,
        input  instr_rvalid_o,
        input  instr_err_o
    );
endinterface

// File: rtl/instr_mem_responder.sv
// Word-organised instruction RAM behind a fetch bus: bounded outstanding grants,
// fixed-latency in-order responses, and a side write port for program preload.
module instr_mem_responder #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    instr_mem_responder_if.slave bus,
    input  logic                 gnt_block_i,
    input  logic                 wr_en_i,
    input  logic [31:0]          wr_addr_i,
    input  logic [31:0]          wr_data_i
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          CW        = 4;
    localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

    logic [31:0]    r_mem [MEM_WORDS];
    logic [CW-1:0]  r_cnt;
    logic           r_pipeValid [LATENCY];
    logic           r_pipeErr   [LATENCY];
    logic [31:0]    r_pipeData  [LATENCY];

    logic [29:0]    w_reqWord;
    logic [29:0]    w_wrWord;
    logic           w_reqInRange;
    logic           w_wrInRange;
    logic [AW-1:0]  w_reqIdx;
    logic [AW-1:0]  w_wrIdx;
    logic [CW-1:0]  w_cntAfterRet;
    logic           w_gnt;
    logic           w_capErr;
    logic [31:0]    w_capData;
    logic           w_unused;

    // Byte offsets are irrelevant for word fetches; compare in word units so nothing wraps.
    assign w_reqWord    = bus.instr_addr_i[31:2] - BASE_WORD;
    assign w_wrWord     = wr_addr_i[31:2] - BASE_WORD;
    assign w_reqInRange = (bus.instr_addr_i[31:2] >= BASE_WORD) && ({2'b00, w_reqWord} < 32'(MEM_WORDS));
    assign w_wrInRange  = (wr_addr_i[31:2] >= BASE_WORD) && ({2'b00, w_wrWord} < 32'(MEM_WORDS));
    assign w_reqIdx     = w_reqWord[AW-1:0];
    assign w_wrIdx      = w_wrWord[AW-1:0];
    assign w_unused     = ^{bus.instr_addr_i[1:0], wr_addr_i[1:0]};

    // A response leaving this cycle frees its slot for a grant in the same cycle.
    assign w_cntAfterRet = r_cnt - CW'(r_pipeValid[LATENCY-1]);
    assign w_gnt         = rstn & bus.instr_req_i & ~gnt_block_i &
                           (w_cntAfterRet < CW'(MAX_OUTSTANDING));

    assign w_capErr  = w_gnt & ~w_reqInRange;
    assign w_capData = (w_gnt && w_reqInRange) ? r_mem[w_reqIdx] : 32'h0;

    assign bus.instr_gnt_o    = w_gnt;
    assign bus.instr_rvalid_o = r_pipeValid[LATENCY-1];
    assign bus.instr_err_o    = r_pipeErr[LATENCY-1];
    assign bus.instr_rdata_o  = r_pipeData[LATENCY-1];

    // Read is sampled before this edge's write lands, so a colliding grant sees old data.
    always_ff @(posedge clk) begin
        if (wr_en_i && w_wrInRange) begin
            r_mem[w_wrIdx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cntAfterRet + CW'(w_gnt);
        end
    end

    // Idle stages carry zero data and err so the outputs read 0 whenever rvalid is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipeValid[i] <= 1'b0;
                r_pipeErr[i]   <= 1'b0;
                r_pipeData[i]  <= 32'h0;
            end
        end else begin
            r_pipeValid[0] <= w_gnt;
            r_pipeErr[0]   <= w_capErr;
            r_pipeData[0]  <= w_capData;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeErr[i]   <= r_pipeErr[i-1];
                r_pipeData[i]  <= r_pipeData[i-1];
            end
        end
    end

    a_rvalidNeedsOutstanding: assert property (@(posedge clk) disable iff (!rstn)
        r_pipeValid[LATENCY-1] |-> (r_cnt != '0));
    a_cntBounded: assert property (@(posedge clk) disable iff (!rstn)
        r_cnt <= CW'(MAX_OUTSTANDING));
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Responder side of the instruction-fetch bus (req/gnt/addr/rdata/rvalid/err). It sits between the fetch stage and a word-organised instruction RAM. Requests are accepted with a grant, and read data is returned in order after a fixed pipeline latency. The number of outstanding transactions is bounded. A side write port preloads the program image, and a backpressure input lets benches throttle grants.

Parameters:
MEM_WORDS, 1024, depth of the instruction RAM in 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)
LATENCY, 2, cycles from grant to rvalid (1..8)
MAX_OUTSTANDING, 2, maximum granted but not-yet-returned requests (1..LATENCY)

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  request accepted this cycle
instr_addr_i  in  32  byte address of requested word
instr_rdata_o  out  32  returned instruction word
instr_rvalid_o  out  1  rdata/err valid this cycle
instr_err_o  out  1  returned access faulted
gnt_block_i  in  1  forces gnt low (test/arbiter backpressure)
wr_en_i  in  1  preload write strobe
wr_addr_i  in  32  preload byte address
wr_data_i  in  32  preload data word

Behaviour:
- Reset (async, rstn low): pipeline valid bits cleared, outstanding count = 0, instr_gnt_o = 0, instr_rvalid_o = 0, instr_err_o = 0, instr_rdata_o = 0. RAM contents are not reset.
- Reset mid-operation drops all in-flight responses; none is ever returned.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS (unsigned compare, no wrap).
  - Out-of-range request is still granted and returns err=1, rdata=0.
- Grant (combinational):
  - gnt = req & ~gnt_block_i & (cnt_q - rvalid_o < MAX_OUTSTANDING).
  - A slot freed by a response in the same cycle is reusable in that cycle.
  - gnt never asserts without req.
- Outstanding counter: cnt_d = cnt_q + gnt - rvalid_o. Never exceeds MAX_OUTSTANDING and never underflows; exceeding either bound is an RTL bug.
- Data capture:
  - On the grant cycle the RAM word (or 0 on error) and the err flag are sampled into stage 0 of a LATENCY-deep shift pipeline.
  - Each stage carries {valid, err, data}.
  - The pipeline advances every cycle; there is no stall from the requester.
- Response: instr_rvalid_o, instr_err_o and instr_rdata_o are registered outputs from the last stage. rvalid rises exactly LATENCY cycles after the grant edge. Order is strictly FIFO.
- rdata/err when rvalid = 0: rdata holds 0 and err holds 0.
- Preload write:
  - wr_en_i writes the RAM at the rising edge when wr_addr_i is in range; out-of-range writes are silently ignored.
  - A write and a grant to the same word in the same cycle return the OLD data.
  - A write in a later cycle never alters an already-granted response.
- Back-to-back: with LATENCY >= MAX_OUTSTANDING and no block, sustained throughput is MAX_OUTSTANDING grants per LATENCY cycles. With MAX_OUTSTANDING = LATENCY it is 1 grant/cycle.
- Assertions:
  - rvalid_o implies cnt_q > 0.
  - Address changes while req is high and not granted are permitted; the address is sampled only on the grant cycle.

Test Plan:
1. Preload words 0..3 with 0x00000013, 0x00100093, 0x00200113, 0x00000073. Issue req @0x0 then @0x4 back-to-back (LATENCY=2, MAX=2). Required: gnt in cycles t and t+1; rvalid in t+2 and t+3 with rdata 0x00000013 then 0x00100093; err=0.
2. MAX_OUTSTANDING=1, LATENCY=2, req held high at 0x8. Required: gnt pattern 1,0,1,0…; each response 0x00200113; cnt_q never >1.
3. req @ BASE_ADDR+4*MEM_WORDS (0x1000 for defaults). Required: gnt=1; two cycles later rvalid=1, err=1, rdata=0. Next request @0xC returns 0x00000073 with err=0.
4. Same cycle: grant @0x4 and wr_en to 0x4 with 0xDEADBEEF. Required: response 0x00100093; a following req @0x4 returns 0xDEADBEEF.
5. gnt_block_i high for 3 cycles with req high @0x0. Required: gnt=0 those cycles, no rvalid. Block released → gnt next cycle, response 0x00000013 after LATENCY.
6. Assert rstn low one cycle after two grants. Required: all outputs 0 immediately; no rvalid after release; cnt_q=0; RAM still returns 0x00000013 @0x0.
